// File: rtl/prbs_pkg.sv
// Shared types, constants and the 32-bit Galois LFSR step for the PRBS generator/checker pair.
package prbs_pkg;

    localparam int unsigned LFSR_W = 32;
    localparam int unsigned RUN_W  = 8;
    localparam int unsigned POP_W  = 6;

    localparam logic [LFSR_W-1:0] LFSR32_SEED = 32'h1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    // Tracking payload: predicted next word plus the match/mismatch run length.
    typedef struct packed {
        logic [LFSR_W-1:0] expected;
        logic [RUN_W-1:0]  run;
    } prbs_track_t;

    function automatic logic [LFSR_W-1:0] lfsr32_next(input logic [LFSR_W-1:0] q);
        logic [LFSR_W-1:0] n;
        n[31]    = q[0];
        n[30:22] = q[31:23];
        n[21]    = q[22] ^ q[0];
        n[20:2]  = q[21:3];
        n[1]     = q[2] ^ q[0];
        n[0]     = q[1] ^ q[0];
        return n;
    endfunction

endpackage

// File: rtl/prbs_popcount32.sv
// Combinational population count of a 32-bit word.
module prbs_popcount32
    import prbs_pkg::*;
(
    input  logic [LFSR_W-1:0] data,
    output logic [POP_W-1:0]  count_c
);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(LFSR_W); i++) begin
            count_c = count_c + POP_W'(data[i]);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising 32-bit PRBS checker with lock tracking and saturating error counting.
// Optional per-bit error counter enabled by defining PRBS_CHK_BITCNT_EN.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned ERR_W    = 16,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_data,
    input  logic              clear_cnt,
    output logic              locked,
    output logic [ERR_W-1:0]  err_count,
    output logic              err_pulse
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [ERR_W-1:0]  bit_err_count
`endif
);

    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [RUN_W:0]   LOCK_RUN = (RUN_W+1)'(LOCK_CNT);
    localparam logic [RUN_W:0]   LOSS_RUN = (RUN_W+1)'(LOSS_CNT);

    prbs_state_t state_q, state_d;
    prbs_track_t track_q, track_d;

    logic           word_zero_c;
    logic           word_match_c;
    logic [RUN_W:0] run_inc_c;
    logic           count_err_c;

    // State and tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            track_q <= '0;
        end else begin
            state_q <= state_d;
            track_q <= track_d;
        end
    end

    // Next-state logic; only valid words advance anything.
    always_comb begin
        state_d      = state_q;
        track_d      = track_q;
        count_err_c  = 1'b0;
        word_zero_c  = (in_data == '0);
        word_match_c = (in_data == track_q.expected);
        run_inc_c    = (RUN_W+1)'(track_q.run) + (RUN_W+1)'(1);

        if (in_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (!word_zero_c) begin
                        track_d.expected = lfsr32_next(in_data);
                        track_d.run      = '0;
                        state_d          = VERIFY;
                    end
                end
                VERIFY: begin
                    if (word_match_c) begin
                        track_d.expected = lfsr32_next(in_data);
                        track_d.run      = run_inc_c[RUN_W-1:0];
                        if (run_inc_c == LOCK_RUN) begin
                            track_d.run = '0;
                            state_d     = LOCKED;
                        end
                    end else if (!word_zero_c) begin
                        track_d.expected = lfsr32_next(in_data);
                        track_d.run      = '0;
                    end else begin
                        track_d.run = '0;
                        state_d     = SEARCH;
                    end
                end
                LOCKED: begin
                    if (word_match_c) begin
                        track_d.expected = lfsr32_next(in_data);
                        track_d.run      = '0;
                    end else begin
                        // Flywheel: keep predicting from our own sequence, not the bad word.
                        count_err_c      = 1'b1;
                        track_d.expected = lfsr32_next(track_q.expected);
                        track_d.run      = run_inc_c[RUN_W-1:0];
                        if (run_inc_c == LOSS_RUN) begin
                            track_d.run = '0;
                            state_d     = SEARCH;
                        end
                    end
                end
                default: begin
                    track_d.run = '0;
                    state_d     = SEARCH;
                end
            endcase
        end
    end

    // Registered status outputs; clear beats a coincident error.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            locked    <= (state_d == LOCKED);
            err_pulse <= count_err_c;
            if (clear_cnt) begin
                err_count <= '0;
            end else if (count_err_c && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    localparam int unsigned SUM_W = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;

    logic [POP_W-1:0] pop_c;
    logic [SUM_W-1:0] bit_sum_c;

    prbs_popcount32 u_popcount (
        .data    (in_data ^ track_q.expected),
        .count_c (pop_c)
    );

    assign bit_sum_c = SUM_W'(bit_err_count) + SUM_W'(pop_c);

    // Saturating sum of differing bits over counted mismatches.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_err_count <= '0;
        end else if (clear_cnt) begin
            bit_err_count <= '0;
        end else if (count_err_c) begin
            bit_err_count <= (bit_sum_c > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(bit_sum_c);
        end
    end
`endif

endmodule
